// File: rtl/vram_fetch_arb.sv
// vram_fetch_arb: shares one VRAM port between the six-plane pixel fetch and a CPU,
// giving the video beam slots 0..5 of each active cell and the CPU every other slot.
module vram_fetch_arb (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [8:0]  h_i,
  input  logic [8:0]  v_i,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [12:0] cpu_addr_i,
  input  logic [7:0]  cpu_wdata_i,
  input  logic [5:0]  cpu_wmask_i,
  input  logic [2:0]  cpu_rsel_i,
  output logic        cpu_ack_o,
  output logic [7:0]  cpu_rdata_o,
  output logic [15:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [7:0]  mem_wdata_o,
  input  logic [7:0]  mem_rdata_i,
  output logic [7:0]  fg1_o,
  output logic [7:0]  fg2_o,
  output logic [7:0]  fg3_o,
  output logic [7:0]  bg1_o,
  output logic [7:0]  bg2_o,
  output logic [7:0]  bg3_o
);
  typedef enum logic [1:0] {IDLE, WRITE, RDWAIT, DONE} state_t;
  state_t      state_q, state_d;
  logic [5:0]  pend_q, pend_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [7:0]  shadow_q [6];
  logic [7:0]  pix_q [6];
  logic [2:0]  slot, wr_plane;
  logic        video, cpu_slot;
  logic [12:0] vid_off;
  assign slot = h_i[2:0];
  assign video = (v_i < 9'd184) && (h_i[8:3] < 6'd24);
  assign cpu_slot = !video || (slot[2:1] == 2'b11);
  assign vid_off = 13'hEC0 + {4'd0, v_i} * 13'd24 + {7'd0, h_i[8:3]};
  assign cpu_rdata_o = rdata_q;
  assign {fg1_o, fg2_o, fg3_o, bg1_o, bg2_o, bg3_o} =
    {pix_q[0], pix_q[1], pix_q[2], pix_q[3], pix_q[4], pix_q[5]};
  // descending scan so the lowest pending plane wins
  always_comb begin
    wr_plane = 3'd0;
    for (int i = 5; i >= 0; i--) if (pend_q[i]) wr_plane = 3'(i);
  end
  always_comb begin
    state_d = state_q;
    pend_d = pend_q;
    rdata_d = rdata_q;
    mem_addr_o = cpu_slot ? 16'h0 : {slot, vid_off};
    mem_we_o = 1'b0;
    mem_wdata_o = 8'h00;
    cpu_ack_o = 1'b0;
    case (state_q)
      IDLE: if (cpu_slot && cpu_req_i) begin
        if (cpu_we_i) begin
          pend_d = cpu_wmask_i;
          state_d = (cpu_wmask_i != 6'd0) ? WRITE : DONE;
        end else if (cpu_rsel_i <= 3'd5) begin
          mem_addr_o = {cpu_rsel_i, cpu_addr_i};
          state_d = RDWAIT;
        end else begin
          rdata_d = 8'hFF;
          state_d = DONE;
        end
      end
      WRITE: if (cpu_slot) begin
        mem_addr_o = {wr_plane, cpu_addr_i};
        mem_we_o = 1'b1;
        mem_wdata_o = cpu_wdata_i;
        pend_d = pend_q & (pend_q - 6'd1);
        state_d = (pend_d == 6'd0) ? DONE : WRITE;
      end
      RDWAIT: begin
        rdata_d = mem_rdata_i;
        state_d = DONE;
      end
      DONE: begin
        cpu_ack_o = 1'b1;
        state_d = IDLE;
      end
    endcase
    // a reset cycle must never leak a write or an ack from the aborted transaction
    if (reset_i) begin
      mem_addr_o = 16'h0;
      mem_we_o = 1'b0;
      mem_wdata_o = 8'h00;
      cpu_ack_o = 1'b0;
    end
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      pend_q <= 6'd0;
      rdata_q <= 8'h00;
      shadow_q <= '{default: 8'h00};
      pix_q <= '{default: 8'h00};
    end else begin
      state_q <= state_d;
      pend_q <= pend_d;
      rdata_q <= rdata_d;
      if (video && slot != 3'd0 && slot != 3'd7) shadow_q[slot - 3'd1] <= mem_rdata_i;
      if (video && slot == 3'd7) pix_q <= shadow_q;
    end
  end
endmodule

// File: tb/tb_vram_fetch_arb.sv
// tb_vram_fetch_arb: directed checks of video fetch, CPU read/write arbitration and reset abort
module tb_vram_fetch_arb;
  logic        clk = 1'b0;
  logic        reset, preload;
  logic [8:0]  h, v;
  logic        cpu_req, cpu_we;
  logic [12:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [5:0]  cpu_wmask;
  logic [2:0]  cpu_rsel;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata, mem_rdata;
  logic [7:0]  fg1, fg2, fg3, bg1, bg2, bg3;
  logic [7:0]  vram [65536];
  int          checks = 0;
  int          errors = 0;
  int          p;
  always #5 clk = ~clk;
  vram_fetch_arb dut (
    .clk_i(clk), .reset_i(reset), .h_i(h), .v_i(v),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
    .cpu_wdata_i(cpu_wdata), .cpu_wmask_i(cpu_wmask), .cpu_rsel_i(cpu_rsel),
    .cpu_ack_o(cpu_ack), .cpu_rdata_o(cpu_rdata),
    .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
    .fg1_o(fg1), .fg2_o(fg2), .fg3_o(fg3), .bg1_o(bg1), .bg2_o(bg2), .bg3_o(bg3)
  );
  // synchronous single-port VRAM, zeroed and seeded once while preload is high
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 65536; i++) vram[i] <= 8'h00;
      for (int k = 0; k < 6; k++) vram[16'(k * 16'h2000 + 16'h0EC0)] <= 8'(8'h10 + k);
      vram[16'h8050] <= 8'h5A;
    end else if (mem_we) vram[mem_addr] <= mem_wdata;
    mem_rdata <= vram[mem_addr];
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input logic [8:0] hh, input logic [8:0] vv);
    @(negedge clk);
    h = hh;
    v = vv;
  endtask
  initial begin
    reset = 1'b1; preload = 1'b1; h = 9'd0; v = 9'd200;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 13'h0; cpu_wdata = 8'h0; cpu_wmask = 6'h0; cpu_rsel = 3'd0;
    cyc(0, 200); preload = 1'b0;
    cyc(0, 200); #1;
    chk("rst_ack", cpu_ack, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_pix", {fg1, fg2, fg3, bg1, bg2, bg3}, 48'h0);
    // first video cell at v=0
    cyc(0, 0); reset = 1'b0; #1;
    chk("vid_addr0", mem_addr, 16'h0EC0);
    for (int hh = 1; hh < 8; hh++) begin
      cyc(9'(hh), 0); #1;
      chk("vid_we", mem_we, 0);
      if (hh < 6) chk("vid_addr", mem_addr, 16'(hh * 16'h2000 + 16'h0EC0));
    end
    cyc(8, 0); #1;
    chk("vid_pix", {fg1, fg2, fg3, bg1, bg2, bg3}, 48'h101112131415);
    cyc(16, 1); #1;
    chk("vid_addr_v1", mem_addr, 16'h0EDA);
    cyc(199, 0); #1;
    cyc(0, 200); #1;
    chk("blank_hold", {fg1, fg2, fg3, bg1, bg2, bg3}, 48'h101112131415);
    // read plane 4 during blanking
    cyc(1, 200); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0050; cpu_rsel = 3'd4; #1;
    chk("rd_addr", mem_addr, 16'h8050);
    chk("rd_we", mem_we, 0);
    chk("rd_ack_accept", cpu_ack, 0);
    cyc(2, 200); #1;
    chk("rd_wait_ack", cpu_ack, 0);
    chk("rd_wait_addr", mem_addr, 0);
    cyc(3, 200); #1;
    chk("rd_ack", cpu_ack, 1);
    chk("rd_data", cpu_rdata, 8'h5A);
    cyc(4, 200); cpu_req = 1'b0; #1;
    chk("rd_ack_pulse", cpu_ack, 0);
    chk("rd_data_hold", cpu_rdata, 8'h5A);
    // read with invalid plane select
    cyc(5, 200); cpu_req = 1'b1; cpu_rsel = 3'd7; #1;
    chk("rd7_addr", mem_addr, 0);
    chk("rd7_we", mem_we, 0);
    cyc(6, 200); #1;
    chk("rd7_ack", cpu_ack, 1);
    chk("rd7_data", cpu_rdata, 8'hFF);
    // six-plane write accepted in a video cell at slot 6
    cyc(6, 10); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0100; cpu_wdata = 8'hAA; cpu_wmask = 6'h3F; #1;
    chk("wr_accept_we", mem_we, 0);
    p = 0;
    for (int hh = 7; hh < 32; hh++) begin
      cyc(9'(hh), 10); #1;
      if (hh == 31) begin
        chk("wr_ack", cpu_ack, 1);
        chk("wr_done_we", mem_we, 0);
      end else if (hh % 8 >= 6) begin
        chk("wr_we", mem_we, 1);
        chk("wr_addr", mem_addr, 16'(p * 16'h2000 + 16'h0100));
        chk("wr_wdata", mem_wdata, 8'hAA);
        chk("wr_ack_early", cpu_ack, 0);
        p++;
      end else begin
        chk("wr_stall_we", mem_we, 0);
        chk("wr_vid_addr", mem_addr, 16'((hh % 8) * 16'h2000 + 16'h0FB0 + hh / 8));
      end
    end
    cyc(32, 10); cpu_req = 1'b0; #1;
    chk("wr_ack_pulse", cpu_ack, 0);
    for (int k = 0; k < 6; k++) chk("wr_vram", vram[16'(k * 16'h2000 + 16'h0100)], 8'hAA);
    // read back plane 3 through the arbiter
    cyc(0, 200); cpu_req = 1'b1; cpu_we = 1'b0; cpu_rsel = 3'd3; #1;
    cyc(1, 200); #1;
    cyc(2, 200); #1;
    chk("rdback_ack", cpu_ack, 1);
    chk("rdback_data", cpu_rdata, 8'hAA);
    cyc(3, 200); cpu_req = 1'b0; #1;
    // write planes 0 and 2, reset after the first write
    cyc(0, 200); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0200; cpu_wdata = 8'h77; cpu_wmask = 6'h05; #1;
    chk("ab_accept_we", mem_we, 0);
    cyc(1, 200); #1;
    chk("ab_we", mem_we, 1);
    chk("ab_addr", mem_addr, 16'h0200);
    cyc(2, 200); reset = 1'b1; cpu_req = 1'b0; #1;
    chk("ab_rst_we", mem_we, 0);
    chk("ab_rst_addr", mem_addr, 0);
    cyc(3, 200); reset = 1'b0; #1;
    chk("ab_ack", cpu_ack, 0);
    chk("ab_we2", mem_we, 0);
    chk("ab_rdata", cpu_rdata, 0);
    chk("ab_pix", {fg1, fg2, fg3, bg1, bg2, bg3}, 48'h0);
    cyc(4, 200); #1;
    chk("ab_ack2", cpu_ack, 0);
    chk("ab_plane0", vram[16'h0200], 8'h77);
    chk("ab_plane2", vram[16'h4200], 8'h00);
    // empty write mask with request held through the ack
    cyc(0, 200); cpu_req = 1'b1; cpu_we = 1'b1; cpu_wmask = 6'h00; #1;
    chk("wm0_we", mem_we, 0);
    chk("wm0_ack0", cpu_ack, 0);
    cyc(1, 200); #1;
    chk("wm0_ack", cpu_ack, 1);
    chk("wm0_we1", mem_we, 0);
    cyc(2, 200); #1;
    chk("wm0_reaccept_ack", cpu_ack, 0);
    cyc(3, 200); #1;
    chk("wm0_ack2", cpu_ack, 1);
    cyc(4, 200); cpu_req = 1'b0; #1;
    cyc(5, 200); #1;
    chk("wm0_idle", cpu_ack, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
